// File: rtl/alu_mc.sv
// alu_mc: ALU with registered single-cycle ops and optional multi-cycle
// shift-add MULU / restoring DIVU, built in when ALU_MC_MULDIV_EN is defined.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf,
    output logic             dbz,
    output logic             illegal
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SRL = 4'd3,
                           OP_SRA = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_NOR = 4'd7,
                           OP_XOR = 4'd8, OP_SLT = 4'd9, OP_SLTU = 4'd10;

    logic             accept, accept_mc;
    logic             fin_valid, fin_dbz;
    logic [WIDTH-1:0] fin_lo, fin_hi;
    logic [WIDTH-1:0] alu_res, sum, diff;
    logic             alu_ovf, alu_ill;

    logic             done_q, done_d, zero_q, zero_d, ovf_q, ovf_d;
    logic             dbz_q, dbz_d, illegal_q, illegal_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;

    assign accept = start && !busy;

    always_comb begin
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SLL:  alu_res = op_b << shamt;
            OP_SRL:  alu_res = op_b >> shamt;
            OP_SRA:  alu_res = $signed(op_b) >>> shamt;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MC_MULDIV_EN
    localparam int CW = SHW + 1;
    localparam logic [3:0] OP_MULU = 4'd11, OP_DIVU = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign busy      = (state_q != S_IDLE);
    assign accept_mc = accept && (op == OP_MULU || op == OP_DIVU);

    // hi/lo hold {partial product, multiplier} or {remainder, dividend->quotient}
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        fin_valid = 1'b0;
        fin_dbz   = 1'b0;
        mul_sum   = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & opnd_q};
        div_sh    = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_sh >= {1'b0, opnd_q};
        div_diff  = div_sh[WIDTH-1:0] - opnd_q;
        case (state_q)
            S_IDLE: if (accept_mc) begin
                state_d = (op == OP_MULU) ? S_MUL : S_DIV;
                hi_d    = '0;
                lo_d    = (op == OP_MULU) ? op_b : op_a;
                opnd_d  = (op == OP_MULU) ? op_a : op_b;
                cnt_d   = '0;
            end
            S_MUL: {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
            S_DIV: begin
                hi_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], div_ge};
            end
            default: state_d = S_IDLE;
        endcase
        if (busy) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
                state_d   = S_IDLE;
                fin_valid = 1'b1;
                fin_dbz   = (state_q == S_DIV) && (opnd_q == '0);
            end
        end
    end

    assign fin_lo = lo_d;
    assign fin_hi = hi_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign busy      = 1'b0;
    assign accept_mc = 1'b0;
    assign fin_valid = 1'b0;
    assign fin_dbz   = 1'b0;
    assign fin_lo    = '0;
    assign fin_hi    = '0;
`endif

    // Visible outputs only change on completion, so iteration state never leaks out.
    always_comb begin
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        illegal_d   = illegal_q;
        if (fin_valid) begin
            done_d      = 1'b1;
            result_d    = fin_lo;
            result_hi_d = fin_hi;
            zero_d      = (fin_lo == '0);
            ovf_d       = 1'b0;
            dbz_d       = fin_dbz;
            illegal_d   = 1'b0;
        end else if (accept && !accept_mc) begin
            done_d      = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            dbz_d       = 1'b0;
            illegal_d   = alu_ill;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            illegal_q   <= illegal_d;
        end
    end

    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;
    assign illegal   = illegal_q;
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 8..64.
REQ-002 Parameter SHW, default 5, shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; accepted only on a clk edge where start=1 and busy=0.
REQ-006 op  input  4  operation code, sampled at acceptance.
REQ-007 op_a, op_b  input  WIDTH  operands, sampled at acceptance.
REQ-008 shamt  input  SHW  shift amount, sampled at acceptance.
REQ-009 busy  output  1  multi-cycle operation in progress.
REQ-010 done  output  1  one-cycle pulse: result/flags valid and updated.
REQ-011 result  output  WIDTH  low result word (quotient for DIVU).
REQ-012 result_hi  output  WIDTH  high product word (MULU) or remainder (DIVU); 0 for other ops.
REQ-013 zero, ovf, dbz, illegal  output  1 each  flags: result==0, signed overflow, divide by zero, unsupported op.

Function
REQ-014 Op codes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 NOR, 8 XOR, 9 SLT (signed), 10 SLTU, 11 MULU, 12 DIVU; 13-15 illegal.
REQ-015 NOR SHALL be bitwise ~(op_a|op_b); SLT/SLTU SHALL yield 1 or 0 zero-extended to WIDTH.
REQ-016 Shifts SHALL shift op_b by shamt; SRA SHALL replicate op_b MSB.
REQ-017 ADD/SUB SHALL be modulo 2^WIDTH; ovf SHALL set on two's-complement overflow, 0 for all other ops.
REQ-018 Single-cycle ops (0-10) and illegal codes: outputs registered at the accept edge, done=1 for the following cycle; busy stays 0.
REQ-019 Illegal codes SHALL give result=0, result_hi=0, illegal=1, zero=1.
REQ-020 FSM states IDLE, MUL, DIV; accept of MULU/DIVU moves IDLE->MUL/DIV, busy=1 from the next cycle.
REQ-021 MULU SHALL be shift-add, one bit per cycle, WIDTH iteration edges; {result_hi,result}=op_a*op_b unsigned, 2*WIDTH bits.
REQ-022 DIVU SHALL be restoring, one bit per cycle, WIDTH iteration edges; result=op_a/op_b, result_hi=op_a%op_b unsigned.
REQ-023 On the last iteration edge FSM returns to IDLE, busy drops and done=1 for one cycle; done thus rises WIDTH cycles after acceptance.
REQ-024 DIVU with op_b=0 SHALL complete with normal latency, result=all ones, result_hi=op_a, dbz=1.
REQ-025 start while busy=1 SHALL be ignored with no effect on the operation in flight or outputs.
REQ-026 start in the done cycle (busy=0) SHALL be accepted normally (back-to-back issue).
REQ-027 result, result_hi and flags SHALL hold their values until the next done; intermediate iteration state SHALL not appear on them.
REQ-028 zero SHALL reflect result only (not result_hi).

Reset
REQ-029 rst=1 SHALL immediately force FSM to IDLE, busy=0, done=0, result=0, result_hi=0, zero=0, ovf=0, dbz=0, illegal=0.
REQ-030 rst asserted mid-MULU/DIVU SHALL abort the operation; no done pulse for it after release.
REQ-031 First start is acceptable on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro ALU_MC_MULDIV_EN defined: MULU/DIVU and states MUL/DIV implemented per REQ-020..REQ-024.
REQ-033 Macro undefined: codes 11-12 treated as illegal per REQ-018/019; busy tied 0; no multiply/divide datapath synthesised.

Verification
REQ-034 WIDTH=32: ADD 0x7FFFFFFF+1 -> done next cycle, result=0x80000000, ovf=1, zero=0.
REQ-035 SRA op_b=0x80000000 shamt=4 -> result=0xF8000000; NOR 0,0 -> 0xFFFFFFFF.
REQ-036 MULU 0xFFFFFFFF*0xFFFFFFFF -> busy 32 cycles, done at cycle 32, result_hi=0xFFFFFFFE, result=0x00000001; start during busy ignored.
REQ-037 DIVU 100/7 -> result=14, result_hi=2; DIVU 5/0 -> result=0xFFFFFFFF, result_hi=5, dbz=1.
REQ-038 rst pulsed at cycle 10 of MULU -> all outputs 0 immediately, no done afterwards; following ADD 1+1 -> result=2.
REQ-039 Build without ALU_MC_MULDIV_EN: op=11 -> done next cycle, illegal=1, result=0, busy never 1.
